bitmap_coord: RTL and testbench

//  Inverse of the linear bitmap address generator: converts a pixel memory address back into

---
 rtl/bitmap_coord.sv | 127 ++++++++++++
 tb/tb_bitmap_coord.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bitmap_coord.sv
// Converts a linear pixel address back into signed (x,y) bitmap coordinates.
// A restoring divider produces one quotient bit per cycle behind valid/ready handshakes.
module bitmap_coord #(
  parameter int CORDW = 16,
  parameter int ADDRW = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADDRW-1:0] addr,
  input  logic [CORDW-1:0] bmpw,
  input  logic [CORDW-1:0] bmph,
  input  logic [CORDW-1:0] offx,
  input  logic [CORDW-1:0] offy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             clip
);

  localparam int CNTW = $clog2(ADDRW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [ADDRW-1:0] dividend;  // shifts out dividend bits, shifts in quotient bits
  logic [CORDW-1:0] rem;
  logic [CNTW-1:0]  count;
  logic [CORDW-1:0] bmpw_r;
  logic [CORDW-1:0] bmph_r;
  logic [CORDW-1:0] offx_r;
  logic [CORDW-1:0] offy_r;
  logic             divzero;

  logic             in_divzero;
  logic [CORDW:0]   rem_shift;
  logic [CORDW:0]   bmpw_ext;
  logic [CORDW:0]   rem_sub;
  logic             rem_ge;
  logic [CORDW-1:0] x_calc;
  logic [CORDW-1:0] y_calc;
  logic [ADDRW+1:0] row_wide;
  logic [ADDRW+1:0] bmph_wide;
  logic             row_ge_h;
  logic             row_big;
  logic             clip_calc;

  assign in_ready   = rst_n && (state == IDLE);
  assign in_divzero = bmpw[CORDW-1] || (bmpw == '0);

  always_comb begin
    rem_shift = {rem, dividend[ADDRW-1]};
    bmpw_ext  = {1'b0, bmpw_r};
    rem_ge    = (rem_shift >= bmpw_ext);
    rem_sub   = rem_ge ? (rem_shift - bmpw_ext) : rem_shift;
  end

  // Row range check is signed so that bmph <= 0 always clips.
  always_comb begin
    x_calc    = rem - offx_r;
    y_calc    = dividend[CORDW-1:0] - offy_r;
    row_wide  = {2'b00, dividend};
    bmph_wide = {{(ADDRW + 2 - CORDW){bmph_r[CORDW-1]}}, bmph_r};
    row_ge_h  = ($signed(row_wide) >= $signed(bmph_wide));
    row_big   = |dividend[ADDRW-1:CORDW-1];
    clip_calc = divzero || row_ge_h || row_big;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dividend  <= '0;
      rem       <= '0;
      count     <= '0;
      bmpw_r    <= '0;
      bmph_r    <= '0;
      offx_r    <= '0;
      offy_r    <= '0;
      divzero   <= 1'b0;
      out_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      clip      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bmpw_r   <= bmpw;
            bmph_r   <= bmph;
            offx_r   <= offx;
            offy_r   <= offy;
            dividend <= addr;
            rem      <= '0;
            count    <= CNTW'(ADDRW);
            divzero  <= in_divzero;
            state    <= in_divzero ? FIN : DIV;
          end
        end
        DIV: begin
          rem      <= rem_sub[CORDW-1:0];
          dividend <= {dividend[ADDRW-2:0], rem_ge};
          count    <= count - 1'b1;
          if (count == CNTW'(1)) state <= FIN;
        end
        FIN: begin
          x         <= divzero ? '0 : x_calc;
          y         <= divzero ? '0 : y_calc;
          clip      <= clip_calc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitmap_coord.sv
// Scoreboard bench for bitmap_coord: directed cases plus random coordinate round trips.
module tb_bitmap_coord;

  localparam int CORDW = 16;
  localparam int ADDRW = 24;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [ADDRW-1:0] addr;
  logic [CORDW-1:0] bmpw;
  logic [CORDW-1:0] bmph;
  logic [CORDW-1:0] offx;
  logic [CORDW-1:0] offy;
  logic             out_valid;
  logic             out_ready;
  logic [CORDW-1:0] x;
  logic [CORDW-1:0] y;
  logic             clip;

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             clip;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  bitmap_coord #(.CORDW(CORDW), .ADDRW(ADDRW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr      (addr),
    .bmpw      (bmpw),
    .bmph      (bmph),
    .offx      (offx),
    .offy      (offy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .y         (y),
    .clip      (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one request, push its expectation, then pop and compare when the result appears.
  task automatic run_req(input int a, input int w, input int h, input int ox, input int oy,
                         input int ex, input int ey, input logic eclip,
                         input int exp_lat, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    int   waited;
    e.x    = CORDW'(ex);
    e.y    = CORDW'(ey);
    e.clip = eclip;
    sb.push_back(e);
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    addr     = ADDRW'(a);
    bmpw     = CORDW'(w);
    bmph     = CORDW'(h);
    offx     = CORDW'(ox);
    offy     = CORDW'(oy);
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the block must use its latched copies.
    in_valid = 1'b0;
    addr     = ADDRW'($urandom);
    bmpw     = CORDW'($urandom);
    bmph     = CORDW'($urandom);
    offx     = CORDW'($urandom);
    offy     = CORDW'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_lat > 0) check_eq("latency", lat, exp_lat);
    else if (lat >= 100) check_eq("out_valid_timeout", lat, 32'd0);
    got = sb.pop_front();
    check_eq("x", {16'd0, x}, {16'd0, got.x});
    check_eq("y", {16'd0, y}, {16'd0, got.y});
    check_eq("clip", {31'd0, clip}, {31'd0, got.clip});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("hold_x", {16'd0, x}, {16'd0, got.x});
      check_eq("hold_y", {16'd0, y}, {16'd0, got.y});
      check_eq("hold_clip", {31'd0, clip}, {31'd0, got.clip});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (hold > 0) begin
      check_eq("release_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    int w, h, ax, ay, ox, oy;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    addr      = '0;
    bmpw      = '0;
    bmph      = '0;
    offx      = '0;
    offy      = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_x", {16'd0, x}, 32'd0);
    check_eq("rst_y", {16'd0, y}, 32'd0);
    check_eq("rst_clip", {31'd0, clip}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_req(291, 100, 50, 0, 0, 91, 2, 1'b0, ADDRW + 1, 0);
    run_req(291, 100, 50, 10, 1, 81, 1, 1'b0, ADDRW + 1, 0);
    run_req(5000, 100, 50, 0, 0, 0, 50, 1'b1, ADDRW + 1, 0);
    run_req(4999, 100, 50, 0, 0, 99, 49, 1'b0, ADDRW + 1, 0);
    run_req(1234, 0, 50, 3, 4, 0, 0, 1'b1, 1, 0);
    run_req(77, -4, 50, 0, 0, 0, 0, 1'b1, 1, 0);
    // Row beyond the signed coordinate range clips even with a huge bmph.
    run_req(32768 * 2 + 1, 2, 32767, 0, 0, 1, 32768, 1'b1, ADDRW + 1, 0);
    run_req(0, 7, 0, 0, 0, 0, 0, 1'b1, ADDRW + 1, 0);
    run_req(291, 100, 50, 0, 0, 91, 2, 1'b0, ADDRW + 1, 10);

    // Reset in the middle of a divide.
    @(negedge clk);
    in_valid = 1'b1;
    addr     = 24'd291;
    bmpw     = 16'd100;
    bmph     = 16'd50;
    offx     = '0;
    offy     = '0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
    run_req(291, 100, 50, 10, 1, 81, 1, 1'b0, ADDRW + 1, 0);

    for (int n = 0; n < 1000; n++) begin
      w  = $urandom_range(1000, 1);
      h  = $urandom_range(1000, 1);
      ax = $urandom_range(w - 1, 0);
      ay = $urandom_range(h - 1, 0);
      ox = $urandom_range(1000, 0) - 500;
      oy = $urandom_range(1000, 0) - 500;
      run_req(w * ay + ax, w, h, ox, oy, ax - ox, ay - oy, 1'b0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
